// File: rtl/time_entry_if.sv
// Keypad-entry bus for time_entry: edit control, key strobe, display scan
// lookup and the committed hour/minute/second outputs.
interface time_entry_if;
    logic        start;
    logic [10:0] cur_hour;
    logic [10:0] cur_minute;
    logic [10:0] cur_second;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [2:0]  light;
    logic [10:0] num;
    logic [2:0]  cursor;
    logic        editing;
    logic [10:0] set_hour;
    logic [10:0] set_minute;
    logic [10:0] set_second;
    logic        set_valid;
    logic        err;

    modport master (
        output start, cur_hour, cur_minute, cur_second, key_valid, key_code, light,
        input  num, cursor, editing, set_hour, set_minute, set_second, set_valid, err
    );

    modport slave (
        input  start, cur_hour, cur_minute, cur_second, key_valid, key_code, light,
        output num, cursor, editing, set_hour, set_minute, set_second, set_valid, err
    );
endinterface

// File: rtl/time_entry.sv
// Keypad time entry: a 6-digit HH-MM-SS edit buffer filled from keypad digits,
// range-checked on enter and committed as one set_valid pulse. The buffer is
// also served to the 7-seg mux by scan position while editing.
module time_entry #(
    parameter int HOUR_MAX       = 23,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic          clk,
    input  logic          rst_n,
    time_entry_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EDIT  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [10:0]   HOUR_LIM = 11'(HOUR_MAX);

    localparam logic [3:0] K_BACK   = 4'd10;
    localparam logic [3:0] K_ENTER  = 4'd11;
    localparam logic [3:0] K_CANCEL = 4'd12;

    state_t        r_state;
    logic [3:0]    r_dig [6];      // d0..d5 = H tens, H units, M tens, M units, S tens, S units
    logic [2:0]    r_idx;          // digit index 0..5; scan position derived below
    logic [CW-1:0] r_cnt;
    logic [10:0]   r_set_hour;
    logic [10:0]   r_set_minute;
    logic [10:0]   r_set_second;
    logic          r_set_valid;
    logic          r_err;

    logic [3:0]    w_pre [6];
    logic [3:0]    w_lim;
    logic [10:0]   w_hour;
    logic [10:0]   w_minute;
    logic [10:0]   w_second;
    logic          w_expire;
    logic [10:0]   w_num;
    logic [2:0]    w_cursor;

    // Preload digits: tens/units split of the current time
    assign w_pre[0] = 4'(bus.cur_hour   / 11'd10);
    assign w_pre[1] = 4'(bus.cur_hour   % 11'd10);
    assign w_pre[2] = 4'(bus.cur_minute / 11'd10);
    assign w_pre[3] = 4'(bus.cur_minute % 11'd10);
    assign w_pre[4] = 4'(bus.cur_second / 11'd10);
    assign w_pre[5] = 4'(bus.cur_second % 11'd10);

    // Decimal reassembly at full 11-bit width (max 99, no truncation)
    assign w_hour   = 11'(r_dig[0]) * 11'd10 + 11'(r_dig[1]);
    assign w_minute = 11'(r_dig[2]) * 11'd10 + 11'(r_dig[3]);
    assign w_second = 11'(r_dig[4]) * 11'd10 + 11'(r_dig[5]);

    // Idle timer expiry; a parameter of 0 disables it entirely
    assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    // Largest digit accepted at the current cursor: tens of hour and of min/sec
    always_comb begin
        w_lim = 4'd9;
        if (r_idx == 3'd0)
            w_lim = 4'd2;
        else if (r_idx == 3'd2 || r_idx == 3'd4)
            w_lim = 4'd5;
    end

    // Digit index to scan position, skipping the separators at 2 and 5
    always_comb begin
        case (r_idx)
            3'd0:    w_cursor = 3'd0;
            3'd1:    w_cursor = 3'd1;
            3'd2:    w_cursor = 3'd3;
            3'd3:    w_cursor = 3'd4;
            3'd4:    w_cursor = 3'd6;
            default: w_cursor = 3'd7;
        endcase
    end

    // Display lookup by scan position; separators show code 11
    always_comb begin
        w_num = 11'd0;
        if (r_state != S_IDLE) begin
            case (bus.light)
                3'd0:    w_num = 11'(r_dig[0]);
                3'd1:    w_num = 11'(r_dig[1]);
                3'd3:    w_num = 11'(r_dig[2]);
                3'd4:    w_num = 11'(r_dig[3]);
                3'd6:    w_num = 11'(r_dig[4]);
                3'd7:    w_num = 11'(r_dig[5]);
                default: w_num = 11'd11;
            endcase
        end
    end

    // Edit FSM: buffer, cursor, idle timer, commit and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            for (int i = 0; i < 6; i++) r_dig[i] <= 4'd0;
            r_idx        <= 3'd0;
            r_cnt        <= '0;
            r_set_hour   <= 11'd0;
            r_set_minute <= 11'd0;
            r_set_second <= 11'd0;
            r_set_valid  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_set_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < 6; i++) r_dig[i] <= w_pre[i];
                        r_idx   <= 3'd0;
                        r_cnt   <= '0;
                        r_state <= S_EDIT;
                    end
                end
                S_EDIT: begin
                    if (bus.key_valid) begin
                        // Any key restarts the idle timer, even one that expires now
                        r_cnt <= '0;
                        if (bus.key_code <= 4'd9) begin
                            if (bus.key_code > w_lim) begin
                                r_err <= 1'b1;
                            end else begin
                                r_dig[r_idx] <= bus.key_code;
                                if (r_idx != 3'd5) r_idx <= r_idx + 3'd1;
                            end
                        end else if (bus.key_code == K_BACK) begin
                            if (r_idx != 3'd0) r_idx <= r_idx - 3'd1;
                        end else if (bus.key_code == K_ENTER) begin
                            r_state <= S_CHECK;
                        end else if (bus.key_code == K_CANCEL) begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_expire) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_cnt <= '0;
                    if (w_hour <= HOUR_LIM) begin
                        r_set_hour   <= w_hour;
                        r_set_minute <= w_minute;
                        r_set_second <= w_second;
                        r_set_valid  <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_err   <= 1'b1;
                        r_idx   <= 3'd0;
                        r_state <= S_EDIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.num        = w_num;
    assign bus.cursor     = w_cursor;
    assign bus.editing    = (r_state != S_IDLE);
    assign bus.set_hour   = r_set_hour;
    assign bus.set_minute = r_set_minute;
    assign bus.set_second = r_set_second;
    assign bus.set_valid  = r_set_valid;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_time_entry.sv
// Scoreboard bench for time_entry: a position-based model of the edit buffer
// predicts commit/error events (queued) and cursor/display values.
`timescale 1ns/1ps
module tb_time_entry;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    time_entry_if bus();

    time_entry #(.HOUR_MAX(23), .TIMEOUT_CYCLES(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        bit commit;
        int h;
        int m;
        int s;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    // Model: buffer indexed by scan position (2 and 5 unused), cursor as position
    int  mbuf [8];
    int  mpos;
    bit  medit;
    int  last_h, last_m, last_s;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int nxt_pos(input int p);
        int q;
        if (p >= 7) return 7;
        q = p + 1;
        if (q == 2 || q == 5) q++;
        return q;
    endfunction

    function automatic int prv_pos(input int p);
        int q;
        if (p <= 0) return 0;
        q = p - 1;
        if (q == 2 || q == 5) q--;
        return q;
    endfunction

    function automatic int pos_limit(input int p);
        if (p == 0) return 2;
        if (p == 3 || p == 6) return 5;
        return 9;
    endfunction

    // Monitor: every commit/error pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (bus.set_valid || bus.err)) begin
            if (expq.size() == 0) begin
                chk("unexpected_event", {30'd0, bus.set_valid, bus.err}, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("event_kind", {30'd0, bus.set_valid, bus.err}, e.commit ? 2 : 1);
                if (e.commit) begin
                    chk("set_hour",   int'(bus.set_hour),   e.h);
                    chk("set_minute", int'(bus.set_minute), e.m);
                    chk("set_second", int'(bus.set_second), e.s);
                end
            end
        end
    end

    task automatic do_start(input int h, input int m, input int s);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.cur_hour = 11'(h); bus.cur_minute = 11'(m); bus.cur_second = 11'(s);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (!medit) begin
            mbuf[0] = h / 10; mbuf[1] = h % 10;
            mbuf[3] = m / 10; mbuf[4] = m % 10;
            mbuf[6] = s / 10; mbuf[7] = s % 10;
            mpos = 0;
            medit = 1;
        end
    endtask

    task automatic press(input int c);
        bit was_enter;
        exp_t e;
        was_enter = 0;
        if (medit) begin
            if (c <= 9) begin
                if (c > pos_limit(mpos)) begin
                    e.commit = 0; e.h = 0; e.m = 0; e.s = 0;
                    expq.push_back(e);
                end else begin
                    mbuf[mpos] = c;
                    mpos = nxt_pos(mpos);
                end
            end else if (c == 10) begin
                mpos = prv_pos(mpos);
            end else if (c == 11) begin
                was_enter = 1;
                e.h = mbuf[0] * 10 + mbuf[1];
                e.m = mbuf[3] * 10 + mbuf[4];
                e.s = mbuf[6] * 10 + mbuf[7];
                if (e.h <= 23) begin
                    e.commit = 1;
                    last_h = e.h; last_m = e.m; last_s = e.s;
                    medit = 0;
                end else begin
                    e.commit = 0;
                    mpos = 0;
                end
                expq.push_back(e);
            end else if (c == 12) begin
                medit = 0;
            end
        end
        @(posedge clk); #1;
        bus.key_valid = 1'b1; bus.key_code = 4'(c);
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        if (was_enter) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("editing", int'(bus.editing), int'(medit));
        if (medit) chk("cursor", int'(bus.cursor), mpos);
    endtask

    task automatic sweep();
        for (int l = 0; l < 8; l++) begin
            bus.light = 3'(l);
            #0.4;
            if (!medit)                 chk("num_idle", int'(bus.num), 0);
            else if (l == 2 || l == 5)  chk("num_sep", int'(bus.num), 11);
            else                        chk("num_digit", int'(bus.num), mbuf[l]);
        end
    endtask

    task automatic check_set();
        chk("hold_hour",   int'(bus.set_hour),   last_h);
        chk("hold_minute", int'(bus.set_minute), last_m);
        chk("hold_second", int'(bus.set_second), last_s);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_editing"},   int'(bus.editing),    0);
        chk({nm, "_cursor"},    int'(bus.cursor),     0);
        chk({nm, "_num"},       int'(bus.num),        0);
        chk({nm, "_set_hour"},  int'(bus.set_hour),   0);
        chk({nm, "_set_min"},   int'(bus.set_minute), 0);
        chk({nm, "_set_sec"},   int'(bus.set_second), 0);
        chk({nm, "_set_valid"}, int'(bus.set_valid),  0);
        chk({nm, "_err"},       int'(bus.err),        0);
    endtask

    initial begin
        int nk;
        bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_code = 4'd0;
        bus.cur_hour = 11'd0; bus.cur_minute = 11'd0; bus.cur_second = 11'd0;
        bus.light = 3'd3;
        for (int i = 0; i < 8; i++) mbuf[i] = 0;
        mpos = 0; medit = 0; last_h = 0; last_m = 0; last_s = 0;

        // Reset state
        #12;
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Preload 12:34:56 and scan the display
        do_start(12, 34, 56);
        @(negedge clk);
        chk("preload_cursor",  int'(bus.cursor),  0);
        chk("preload_editing", int'(bus.editing), 1);
        sweep();

        // Full entry 23:59:07
        press(2); press(3); press(5); press(9); press(0); press(7);
        press(11);
        chk("commit_hour",    int'(bus.set_hour),   23);
        chk("commit_minute",  int'(bus.set_minute), 59);
        chk("commit_second",  int'(bus.set_second), 7);
        chk("commit_editing", int'(bus.editing),    0);

        // Range rejects: 3 at pos0, 6 at pos3
        do_start(12, 34, 56);
        press(3);
        press(1); press(2);
        press(6);
        chk("reject_cursor", int'(bus.cursor), 3);
        sweep();

        // Hour overflow 24:00:00
        press(10); press(10); press(10);
        press(2); press(4); press(0); press(0); press(0); press(0);
        press(11);
        chk("overflow_cursor",  int'(bus.cursor),  0);
        chk("overflow_editing", int'(bus.editing), 1);

        // Navigation: back at 0, fill, overwrite at 7, cancel
        press(10);
        press(1); press(0); press(0); press(0); press(0); press(0);
        press(7);
        chk("sat_cursor", int'(bus.cursor), 7);
        sweep();
        press(12);
        check_set();

        // Timeout: 20 idle cycles in EDIT abandon the edit
        do_start(5, 6, 7);
        repeat (19) @(posedge clk);
        #1 chk("timeout_before", int'(bus.editing), 1);
        @(posedge clk);
        #1 chk("timeout_after", int'(bus.editing), 0);
        medit = 0;
        check_set();

        // Randomized sessions
        for (int r = 0; r < 40; r++) begin
            do_start($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            nk = 0;
            while (medit && nk < 25) begin
                press($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) sweep();
                repeat ($urandom_range(0, 3)) @(posedge clk);
                nk++;
            end
            if (medit) press(12);
            check_set();
        end

        // Reset mid-edit
        do_start(9, 8, 7);
        press(1); press(2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        bus.light = 3'd3;
        medit = 0; mpos = 0; last_h = 0; last_m = 0; last_s = 0;
        check_all_zero("mid_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("after_mid_reset");

        repeat (4) @(posedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_entry.md
Name: time_entry

Overview:
- Inverse of the display digit scanner: the scanner turns hour/minute/second into per-position digits; this block turns per-position keypad digits back into hour/minute/second.
- Holds a 6-digit edit buffer in HH-MM-SS layout on scan positions 0-7, with separators at 2 and 5.
- Validates the buffer and, on commit, emits one set_valid pulse with the new values for the clock/alarm registers.
- Also serves the buffer back to the 7-seg mux by scan position, so the display shows the value being edited.

Parameters:
HOUR_MAX, 23, largest hour accepted at commit.
TIMEOUT_CYCLES, 5000, clk cycles with no key before an edit is abandoned; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin edit, preload buffer from cur_*
cur_hour  in  11  current hour, 0..23
cur_minute  in  11  current minute, 0..59
cur_second  in  11  current second, 0..59
key_valid  in  1  one-cycle strobe qualifying key_code
key_code  in  4  0-9 digit, 10 back, 11 enter, 12 cancel, 13-15 ignored
light  in  3  display scan position 0..7
num  out  11  digit at light while editing: buffer digit, or 11 at positions 2/5; 0 when not editing
cursor  out  3  current edit position: 0,1,3,4,6,7
editing  out  1  high in EDIT and CHECK
set_hour  out  11  committed hour
set_minute  out  11  committed minute
set_second  out  11  committed second
set_valid  out  1  one-cycle commit pulse
err  out  1  one-cycle pulse on any rejected key or failed commit

Behaviour:
Reset (async, rst_n low):
- state=IDLE, buffer digits=0, cursor=0, editing=0, set_*=0, set_valid=0, err=0, timeout counter=0.
- Recovery is synchronous to clk.
- Reset mid-edit discards the buffer; no set_valid.

States:
- IDLE:
  - start loads d0..d5 = tens/units of cur_hour, cur_minute, cur_second; cursor=0; goes to EDIT next cycle.
  - Keys are ignored.
- EDIT, on key_valid:
  - digit: per-position limit is pos0 <=2, pos3 <=5, pos6 <=5, others <=9.
  - digit within limit: written at cursor, cursor advances 0->1->3->4->6->7 and saturates at 7.
  - digit over limit: buffer and cursor unchanged, err pulses.
  - back (10): cursor moves to the previous position; saturates at 0, no wrap; buffer unchanged.
  - enter (11): goes to CHECK.
  - cancel (12): goes to IDLE with no set_valid.
  - codes 13-15: ignored, no err.
  - start while in EDIT: ignored.
- CHECK (exactly one cycle):
  - hour = 10*d0+d1, minute = 10*d2+d3, second = 10*d4+d5.
  - If hour <= HOUR_MAX: set_* load the values and set_valid=1 for one cycle, then go to IDLE.
  - Otherwise: err=1, cursor=0, return to EDIT with buffer kept.

Timing:
- Key in cycle N: buffer, cursor and err are visible in cycle N+1.
- Enter in cycle N: CHECK in N+1; set_valid or err in N+2.
- set_* hold their value until the next commit or reset.

Timeout:
- The counter clears on every key_valid and on entering EDIT.
- In EDIT, the counter reaching TIMEOUT_CYCLES gives the same result as cancel.
- If key_valid arrives in the same cycle the counter expires, the key wins and the counter clears.

Display path:
- num is combinational from light and the buffer.
- light 0,1,3,4,6,7 map to d0..d5; light 2,5 give 11; num is 0 when editing=0.

Arithmetic:
- Products are formed at 11 bits with no truncation; the maximum is 99.

Test Plan:
- Preload: reset, cur=12:34:56, start, then light swept 0..7 -> num = 1,2,11,3,4,11,5,6; cursor=0; editing=1.
- Full entry: keys 2,3,5,9,0,7 then enter -> set_valid in the cycle 2 after enter; set_hour=23, set_minute=59, set_second=7; editing=0.
- Range reject: key 6 at cursor 3 -> err pulse, buffer and cursor unchanged; key 3 at cursor 0 -> err pulse.
- Hour overflow: buffer 2,4,0,0,0,0 then enter -> err in CHECK+1 cycle, cursor=0, still EDIT, no set_valid.
- Navigation: back at cursor 0 -> cursor stays 0; key 7 at cursor 7 -> d5=7, cursor stays 7; cancel -> IDLE, set_* unchanged.
- Timeout/reset: TIMEOUT_CYCLES=20, no keys -> IDLE after 20 cycles with no set_valid; separately, rst_n low mid-edit -> all outputs 0 immediately.
